alu_mc: RTL and testbench

Multi-cycle, parametrised successor of the single-cycle execute ALU. It keeps the base integer operation set and the `zero`/`less` flags, and adds RV32M/RV64M multiply and divide through an iterative datapath. Transactions use a valid/ready handshake on both input and output. It sits in the EX stage, between the operand-forwarding muxes and the EX/MEM register; the pipeline stalls while `in_ready` is low.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mc_mdu_iter.sv | 122 ++++++++++++
 rtl/alu_mc.sv | 126 ++++++++++++
 tb/tb_alu_mc.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and decode helper for the multi-cycle execute ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b01000;
  localparam logic [4:0] OP_SLL    = 5'b00001;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_SLTU   = 5'b01010;
  localparam logic [4:0] OP_PASSB  = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SRA    = 5'b01101;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_AND    = 5'b00111;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic is_mdu(input logic [4:0] op);
    return op[4];
  endfunction

endpackage

// File: rtl/alu_mc_mdu_iter.sv
// Iterative multiply (shift-add) / divide (restoring) on operand magnitudes,
// one bit per cycle, followed by a single sign-fixup cycle.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic             run_q, run_d, fix_q, fix_d, neg_q, neg_d, rneg_q, rneg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       func_q, func_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;

  logic              is_div, sa, sb, na, nb;
  logic [XLEN-1:0]   ma, mb, addend, quo, rem;
  logic [XLEN:0]     msum, dsh, ddiff;
  logic [2*XLEN-1:0] prod;

  assign last   = run_q && (cnt_q == '0);
  assign done   = fix_q;

  always_comb begin
    is_div = func[2];
    sa     = is_div ? !func[0] : (func != OP_MULHU[2:0]);
    sb     = is_div ? !func[0] : (func == OP_MUL[2:0] || func == OP_MULH[2:0]);
    na     = sa && a[XLEN-1];
    nb     = sb && b[XLEN-1];
    ma     = na ? -a : a;
    mb     = nb ? -b : b;

    // multiply: hi:lo holds partial product over the remaining multiplier bits
    addend = lo_q[0] ? opd_q : '0;
    msum   = {1'b0, hi_q} + {1'b0, addend};
    // divide: hi is the partial remainder, lo shifts dividend out / quotient in
    dsh    = {hi_q, lo_q[XLEN-1]};
    ddiff  = dsh - {1'b0, opd_q};

    run_d  = run_q;
    fix_d  = 1'b0;
    cnt_d  = cnt_q;
    func_d = func_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opd_d  = opd_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;

    if (flush) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      run_d  = 1'b1;
      cnt_d  = CNT_W'(XLEN - 1);
      func_d = func;
      hi_d   = '0;
      lo_d   = is_div ? ma : mb;
      opd_d  = is_div ? mb : ma;
      neg_d  = na ^ nb;
      rneg_d = na;
    end else if (run_q) begin
      if (func_q[2]) begin
        hi_d = ddiff[XLEN] ? dsh[XLEN-1:0] : ddiff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], !ddiff[XLEN]};
      end else begin
        hi_d = msum[XLEN:1];
        lo_d = {msum[0], lo_q[XLEN-1:1]};
      end
      if (cnt_q == '0) begin
        run_d = 1'b0;
        fix_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo  = neg_q ? -lo_q : lo_q;
    rem  = rneg_q ? -hi_q : hi_q;
    if (func_q[2])                     result = func_q[1] ? rem : quo;
    else if (func_q == OP_MUL[2:0])    result = prod[XLEN-1:0];
    else                               result = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      fix_q  <= 1'b0;
      cnt_q  <= '0;
      func_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opd_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      fix_q  <= fix_d;
      cnt_q  <= cnt_d;
      func_q <= func_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opd_q  <= opd_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle base ops and divide special cases,
// iterative RV M-extension ops, valid/ready on both sides.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less,
  output logic            busy
);

  localparam int SH_W = $clog2(XLEN);

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d, less_q, less_d;

  logic            accept, mdu_go, special, div0, ovf, lt_s, lt_u, lt;
  logic            mdu_last, mdu_done;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] sra_res, base_res, spec_res, fast_res, mdu_res;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign accept    = in_valid && in_ready && !flush;
  assign result    = result_q;
  assign zero      = zero_q;
  assign less      = less_q;

  always_comb begin
    shamt   = b[SH_W-1:0];
    lt_s    = $signed(a) < $signed(b);
    lt_u    = a < b;
    sra_res = $signed(a) >>> shamt;
    case (op[2:0])
      3'd0:    base_res = op[3] ? a - b : a + b;
      3'd1:    base_res = a << shamt;
      3'd2:    base_res = {{(XLEN-1){1'b0}}, op[3] ? lt_u : lt_s};
      3'd3:    base_res = b;
      3'd4:    base_res = a ^ b;
      3'd5:    base_res = op[3] ? sra_res : a >> shamt;
      3'd6:    base_res = a | b;
      default: base_res = a & b;
    endcase

    // divide corner cases bypass the iterative unit entirely
    div0     = (b == '0);
    ovf      = !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = op[4] && op[2] && (div0 || ovf);
    spec_res = div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    fast_res = op[4] ? spec_res : base_res;
    lt       = !op[4] && (op[3] ? lt_u : lt_s);
    mdu_go   = accept && is_mdu(op) && !special;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    less_d   = less_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept)                           state_d = mdu_go ? CALC : DONE;
          else if (state_q == DONE && out_ready) state_d = IDLE;
        end
        CALC:    if (mdu_last) state_d = FIX;
        FIX:     state_d = DONE;
        default: state_d = IDLE;
      endcase
      if (accept && !mdu_go) begin
        result_d = fast_res;
        zero_d   = (fast_res == '0);
        less_d   = lt;
      end else if (state_q == FIX && mdu_done) begin
        result_d = mdu_res;
        zero_d   = (mdu_res == '0);
        less_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      less_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      less_q   <= less_d;
    end
  end

  mdu_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (mdu_go),
    .func   (op[2:0]),
    .a      (a),
    .b      (b),
    .last   (mdu_last),
    .done   (mdu_done),
    .result (mdu_res)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at XLEN=32 and XLEN=64: directed vector table, corner
// sequences, and random ops against an arithmetic reference model.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, iv, out_ready, sel64;
  logic [4:0]  op;
  logic [63:0] a, b;

  logic        in_ready32, out_valid32, zero32, less32, busy32, iv32;
  logic        in_ready64, out_valid64, zero64, less64, busy64, iv64;
  logic [31:0] res32;
  logic [63:0] res64;

  logic        cur_ir, cur_ov, cur_z, cur_l, cur_busy;
  logic [63:0] cur_res;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign iv32     = iv && !sel64;
  assign iv64     = iv && sel64;
  assign cur_ir   = sel64 ? in_ready64  : in_ready32;
  assign cur_ov   = sel64 ? out_valid64 : out_valid32;
  assign cur_z    = sel64 ? zero64      : zero32;
  assign cur_l    = sel64 ? less64      : less32;
  assign cur_busy = sel64 ? busy64      : busy32;
  assign cur_res  = sel64 ? res64       : {32'b0, res32};

  alu_mc #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv32), .in_ready(in_ready32),
    .op(op), .a(a[31:0]), .b(b[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
    .result(res32), .zero(zero32), .less(less32), .busy(busy32)
  );

  alu_mc #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv64), .in_ready(in_ready64),
    .op(op), .a(a), .b(b), .out_valid(out_valid64), .out_ready(out_ready),
    .result(res64), .zero(zero64), .less(less64), .busy(busy64)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Starts at posedge+1; returns at the first cycle out_valid is seen.
  task automatic do_op(input logic [4:0] o, input logic [63:0] av, input logic [63:0] bv,
                       input logic rdy_after, output logic [63:0] r, output logic z,
                       output logic l, output int lat, output int busy_n, output int stall_bad);
    int n;
    op = o; a = av; b = bv; iv = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!cur_ir && n < 200) begin @(posedge clk); #1; n++; end
    chk("in_ready_timeout", cur_ir, 1);
    @(posedge clk); #1;
    iv = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 5'($urandom);
    out_ready = rdy_after;
    lat = 1; busy_n = 0; stall_bad = 0;
    while (!cur_ov && lat < 200) begin
      if (cur_busy) busy_n++;
      if (cur_ir) stall_bad++;
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_timeout", cur_ov, 1);
    r = cur_res; z = cur_z; l = cur_l;
  endtask

  function automatic logic [63:0] model(input logic [4:0] o, input logic [63:0] av,
                                        input logic [63:0] bv, input bit w64,
                                        output logic lz, output logic ll, output int lat);
    int w;
    int sh;
    logic [63:0] mask, am, bm, r;
    logic [127:0] au, bu, pu;
    logic signed [127:0] as_, bs_, ps;
    logic div0, ovf;
    w    = w64 ? 64 : 32;
    mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    am   = av & mask;
    bm   = bv & mask;
    au   = {64'b0, am};
    bu   = {64'b0, bm};
    as_  = w64 ? $signed({{64{am[63]}}, am}) : $signed({{96{am[31]}}, am[31:0]});
    bs_  = w64 ? $signed({{64{bm[63]}}, bm}) : $signed({{96{bm[31]}}, bm[31:0]});
    sh   = int'(bm[5:0]) & (w - 1);
    lat  = 1;
    r    = '0;
    if (!o[4]) begin
      case (o[2:0])
        3'd0: r = o[3] ? am - bm : am + bm;
        3'd1: r = am << sh;
        3'd2: r = (o[3] ? (au < bu) : (as_ < bs_)) ? 64'd1 : 64'd0;
        3'd3: r = bm;
        3'd4: r = am ^ bm;
        3'd5: begin
          ps = as_ >>> sh;
          r  = o[3] ? ps[63:0] : am >> sh;
        end
        3'd6: r = am | bm;
        default: r = am & bm;
      endcase
    end else begin
      div0 = (bm == 64'd0);
      ovf  = !o[0] && (am == (64'd1 << (w - 1))) && (bm == mask);
      case (o[2:0])
        3'd0: begin ps = as_ * bs_; r = ps[63:0]; end
        3'd1: begin ps = (as_ * bs_) >>> w; r = ps[63:0]; end
        3'd2: begin ps = (as_ * $signed(bu)) >>> w; r = ps[63:0]; end
        3'd3: begin pu = (au * bu) >> w; r = pu[63:0]; end
        3'd4: begin ps = as_ / (div0 ? 128'sd1 : bs_); r = div0 ? mask : ps[63:0]; end
        3'd5: begin pu = au / (div0 ? 128'd1 : bu); r = div0 ? mask : pu[63:0]; end
        3'd6: begin ps = as_ % (div0 ? 128'sd1 : bs_); r = div0 ? am : ps[63:0]; end
        default: begin pu = au % (div0 ? 128'd1 : bu); r = div0 ? am : pu[63:0]; end
      endcase
      lat = (o[2] && (div0 || ovf)) ? 1 : w + 2;
    end
    r  = r & mask;
    lz = (r == 64'd0);
    ll = o[4] ? 1'b0 : (o[3] ? (au < bu) : (as_ < bs_));
    return r;
  endfunction

  function automatic logic [63:0] rand_val(input bit w64);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = w64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      3:       v = 64'($urandom_range(0, 20));
      4:       v = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 9));
      default: v = {$urandom, $urandom};
    endcase
    return w64 ? v : (v & 64'h0000_0000_FFFF_FFFF);
  endfunction

  typedef struct {
    bit          w64;
    logic [4:0]  op;
    logic [63:0] a, b, res;
    logic        z;
    int          lat;
  } vec_t;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    logic [63:0] r, er;
    logic z, l, ez, el;
    int lat, bn, sb, elat, cnt;

    vt.push_back('{0, OP_SUB,    64'd5,          64'd5,          64'd0,          1'b1, 1});
    vt.push_back('{0, OP_SLTU,   64'd1,          64'hFFFFFFFF,   64'd1,          1'b0, 1});
    vt.push_back('{0, OP_SLT,    64'd1,          64'hFFFFFFFF,   64'd0,          1'b1, 1});
    vt.push_back('{0, OP_SRA,    64'h80000000,   64'd31,         64'hFFFFFFFF,   1'b0, 1});
    vt.push_back('{0, OP_SRL,    64'h80000000,   64'd31,         64'd1,          1'b0, 1});
    vt.push_back('{0, OP_SLL,    64'd1,          64'd33,         64'd2,          1'b0, 1});
    vt.push_back('{0, OP_ADD,    64'hFFFFFFFF,   64'd1,          64'd0,          1'b1, 1});
    vt.push_back('{0, OP_MULH,   64'hFFFFFFFE,   64'd3,          64'hFFFFFFFF,   1'b0, 34});
    vt.push_back('{0, OP_DIV,    64'd7,          64'd0,          64'hFFFFFFFF,   1'b0, 1});
    vt.push_back('{0, OP_REM,    64'h80000000,   64'hFFFFFFFF,   64'd0,          1'b1, 1});
    vt.push_back('{0, OP_DIV,    64'h80000000,   64'hFFFFFFFF,   64'h80000000,   1'b0, 1});
    vt.push_back('{0, OP_REMU,   64'd5,          64'd0,          64'd5,          1'b0, 1});
    vt.push_back('{0, OP_REM,    64'hFFFFFFF9,   64'd2,          64'hFFFFFFFF,   1'b0, 34});
    vt.push_back('{0, OP_DIVU,   64'd100,        64'd7,          64'd14,         1'b0, 34});
    vt.push_back('{0, OP_MUL,    64'hFFFFFFFF,   64'hFFFFFFFF,   64'd1,          1'b0, 34});
    vt.push_back('{0, OP_MULHSU, 64'hFFFFFFFF,   64'd2,          64'hFFFFFFFF,   1'b0, 34});
    vt.push_back('{1, OP_MULH,   64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66});
    vt.push_back('{1, OP_DIV,    64'd7,          64'd0,          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1});
    vt.push_back('{1, OP_SRA,    64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1});

    rst = 1'b1; flush = 1'b0; iv = 1'b0; out_ready = 1'b0; sel64 = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      chk("rst_out_valid", cur_ov, 0);
      chk("rst_busy", cur_busy, 0);
      chk("rst_in_ready", cur_ir, 1);
      chk("rst_result", cur_res, 0);
      chk("rst_zero", cur_z, 0);
      chk("rst_less", cur_l, 0);
    end
    rst = 1'b0;
    sel64 = 1'b0;

    foreach (vt[i]) begin
      sel64 = vt[i].w64;
      do_op(vt[i].op, vt[i].a, vt[i].b, 1'b1, r, z, l, lat, bn, sb);
      chk($sformatf("vec%0d_res", i), r, vt[i].res);
      chk($sformatf("vec%0d_zero", i), z, vt[i].z);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bn, (vt[i].lat > 1) ? vt[i].lat - 1 : 0);
      chk($sformatf("vec%0d_in_ready_while_busy", i), sb, 0);
    end

    // back-to-back base ops, one result per cycle
    sel64 = 1'b0;
    @(posedge clk); #1;
    op = OP_ADD; iv = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 64'(i * 10); b = 64'd1;
      @(posedge clk); #1;
      chk("b2b_valid", cur_ov, 1);
      chk("b2b_res", cur_res, 64'(i * 10 + 1));
    end
    iv = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", cur_ov, 0);

    // backpressure hold, then flush blocks a same-cycle accept from DONE
    do_op(OP_DIVU, 64'd100, 64'd7, 1'b0, r, z, l, lat, bn, sb);
    chk("bp_first", r, 64'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_res", cur_res, 64'd14);
      chk("bp_hold_valid", cur_ov, 1);
      chk("bp_in_ready", cur_ir, 0);
    end
    out_ready = 1'b1; flush = 1'b1; iv = 1'b1; op = OP_ADD; a = 64'd1; b = 64'd2;
    @(posedge clk); #1;
    flush = 1'b0; iv = 1'b0;
    chk("bpflush_valid", cur_ov, 0);
    chk("bpflush_in_ready", cur_ir, 1);

    // flush during CALC with a new op presented
    op = OP_MULH; a = 64'd5; b = 64'd6; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("calc_busy", cur_busy, 1);
    flush = 1'b1; iv = 1'b1; op = OP_ADD;
    @(posedge clk); #1;
    flush = 1'b0; iv = 1'b0;
    chk("flush_valid", cur_ov, 0);
    chk("flush_busy", cur_busy, 0);
    chk("flush_in_ready", cur_ir, 1);
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (cur_ov || cur_busy) cnt++; end
    chk("flush_quiet", cnt, 0);

    // reset mid-CALC
    op = OP_DIV; a = 64'd1000; b = 64'd3; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstcalc_in_ready", cur_ir, 1);
    chk("rstcalc_valid", cur_ov, 0);
    chk("rstcalc_busy", cur_busy, 0);
    chk("rstcalc_result", cur_res, 0);
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (cur_ov) cnt++; end
    chk("rstcalc_quiet", cnt, 0);

    // random ops against the reference model, both widths
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      for (int k = 0; k < 120; k++) begin
        logic [4:0] o;
        logic [63:0] av, bv;
        o  = 5'($urandom_range(0, 31));
        av = rand_val(s == 1);
        bv = rand_val(s == 1);
        er = model(o, av, bv, s == 1, ez, el, elat);
        do_op(o, av, bv, 1'b1, r, z, l, lat, bn, sb);
        chk($sformatf("rnd_res w%0d op%0d a=%h b=%h", s, o, av, bv), r, er);
        chk($sformatf("rnd_zero w%0d op%0d", s, o), z, ez);
        chk($sformatf("rnd_less w%0d op%0d", s, o), l, el);
        chk($sformatf("rnd_lat w%0d op%0d", s, o), lat, elat);
      end
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
